// File: rtl/sd_wr_pkg.sv
// Shared state type and defaults for the SD write sector buffer.
package sd_wr_pkg;
    typedef enum logic [2:0] {
        FILL,
        PAD,
        WAIT_IDLE,
        START,
        WAIT_BUSY,
        DRAIN,
        DONE
    } state_t;

    localparam int          SEC_WORDS_DEF = 256;
    localparam logic [15:0] PAD_WORD_DEF  = 16'h0000;
endpackage

// File: rtl/sd_sec_ram.sv
// One-sector word buffer: one write port, one registered read port.
// Only the read register is reset so wr_data has a defined value out of reset.
module sd_sec_ram
    import sd_wr_pkg::*;
#(
    parameter int SEC_WORDS = SEC_WORDS_DEF,
    parameter int AW        = 8
) (
    input  logic          clk_ref,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);
    logic [15:0] mem_q [SEC_WORDS];
    logic [15:0] rdata_q;

    always_ff @(posedge clk_ref) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sd_wr_sector_buf.sv
// Collects a sector of upstream words, then hands it to the SD write engine.
// State       | meaning
// FILL        | accept upstream words into the buffer
// PAD         | fill the rest of a flushed partial sector with PAD_WORD
// WAIT_IDLE   | wait for card ready and engine idle, preload word 0
// START       | launch the write (pulse appears the following cycle)
// WAIT_BUSY   | wait for the engine to go busy
// DRAIN       | serve words on wr_req until the engine drops busy
// DONE        | count the sector and rearm for the next fill
module sd_wr_sector_buf
    import sd_wr_pkg::*;
#(
    parameter int          SEC_WORDS = SEC_WORDS_DEF,
    parameter int          AW        = 8,
    parameter logic [15:0] PAD_WORD  = PAD_WORD_DEF
) (
    input  logic        clk_ref,
    input  logic        rst,
    input  logic        sd_init_done,
    input  logic [31:0] base_sec_addr,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        flush,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic [15:0] wr_data,
    input  logic        wr_req,
    input  logic        wr_busy,
    output logic        sec_done,
    output logic [31:0] sec_cnt,
    output logic        err_ovr
);
    localparam logic [AW:0] FULL = (AW+1)'(SEC_WORDS);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t      state_q, state_d;
    logic [AW:0] fill_q, fill_d;
    logic [AW:0] ridx_q, ridx_d;
    logic [AW:0] served_q, served_d;
    logic [31:0] base_q, base_d;
    logic [31:0] sec_cnt_q, sec_cnt_d;
    logic [31:0] wr_sec_addr_q, wr_sec_addr_d;
    logic        wr_start_en_q, wr_start_en_d;
    logic        err_ovr_q, err_ovr_d;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [15:0]   ram_wdata;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;

    sd_sec_ram #(
        .SEC_WORDS (SEC_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk_ref (clk_ref),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (wr_data)
    );

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state_q       <= FILL;
            fill_q        <= '0;
            ridx_q        <= '0;
            served_q      <= '0;
            base_q        <= '0;
            sec_cnt_q     <= '0;
            wr_sec_addr_q <= '0;
            wr_start_en_q <= 1'b0;
            err_ovr_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            ridx_q        <= ridx_d;
            served_q      <= served_d;
            base_q        <= base_d;
            sec_cnt_q     <= sec_cnt_d;
            wr_sec_addr_q <= wr_sec_addr_d;
            wr_start_en_q <= wr_start_en_d;
            err_ovr_q     <= err_ovr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        ridx_d        = ridx_q;
        served_d      = served_q;
        base_d        = base_q;
        sec_cnt_d     = sec_cnt_q;
        wr_sec_addr_d = wr_sec_addr_q;
        wr_start_en_d = 1'b0;
        err_ovr_d     = err_ovr_q;
        ram_we        = 1'b0;
        ram_waddr     = fill_q[AW-1:0];
        ram_wdata     = in_data;
        ram_re        = 1'b0;
        ram_raddr     = ridx_q[AW-1:0];

        if (state_q == FILL && sec_cnt_q == 32'd0) begin
            base_d = base_sec_addr;
        end

        // Word 0 is already on wr_data, so each request prefetches the next index.
        if ((state_q == WAIT_BUSY || state_q == DRAIN) && wr_req) begin
            if (served_q < FULL) begin
                served_d = served_q + ONE;
                if (ridx_q < FULL) begin
                    ram_re = 1'b1;
                    ridx_d = ridx_q + ONE;
                end
            end else begin
                err_ovr_d = 1'b1;
            end
        end

        case (state_q)
            FILL: begin
                if (in_valid && in_ready) begin
                    ram_we = 1'b1;
                    fill_d = fill_q + ONE;
                    if (fill_q + ONE == FULL) begin
                        state_d = WAIT_IDLE;
                    end else if (flush) begin
                        state_d = PAD;
                    end
                end else if (flush && fill_q != '0) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                ram_we    = 1'b1;
                ram_wdata = PAD_WORD;
                fill_d    = fill_q + ONE;
                if (fill_q + ONE == FULL) begin
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                ram_re    = 1'b1;
                ram_raddr = '0;
                if (sd_init_done && !wr_busy) begin
                    state_d = START;
                end
            end
            START: begin
                wr_start_en_d = 1'b1;
                wr_sec_addr_d = base_q + sec_cnt_q;
                ridx_d        = ONE;
                served_d      = '0;
                state_d       = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (wr_busy) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!wr_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                sec_cnt_d = sec_cnt_q + 32'd1;
                fill_d    = '0;
                ridx_d    = '0;
                state_d   = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Held low while reset is asserted so upstream never sees a ready during reset.
    assign in_ready    = !rst && (state_q == FILL) && (fill_q < FULL);
    assign wr_start_en = wr_start_en_q;
    assign wr_sec_addr = wr_sec_addr_q;
    assign sec_done    = (state_q == DONE);
    assign sec_cnt     = sec_cnt_q;
    assign err_ovr     = err_ovr_q;
endmodule
